// File: rtl/sample_capture_ram.sv
// Dual-port on-chip RAM: an Avalon-MM CPU port with byte lanes and pipelined reads,
// plus a streaming capture engine that fills a circular window of the same array.
module sample_capture_ram #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 37500,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,

  input  logic                    cap_start,
  input  logic [ADDR_WIDTH-1:0]   cap_base,
  input  logic [ADDR_WIDTH:0]     cap_len,
  input  logic                    snk_valid,
  input  logic [DATA_WIDTH-1:0]   snk_data,
  output logic                    snk_ready,
  output logic                    cap_busy,
  output logic                    cap_done,
  output logic [ADDR_WIDTH:0]     cap_count,
  output logic [ADDR_WIDTH-1:0]   cap_wr_ptr
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

  cap_state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cpu_in_range;
  logic                  cpu_wr_en;
  logic                  cpu_rd_en;
  logic                  cap_wr_en;
  logic                  base_in_range;
  logic [ADDR_WIDTH:0]   cap_len_q;
  logic [ADDR_WIDTH:0]   cap_count_nxt;
  logic [ADDR_WIDTH-1:0] cap_wr_ptr_nxt;

  logic [DATA_WIDTH-1:0] rd_data_s1;
  logic                  rd_valid_s1;

  generate
    if ((DATA_WIDTH % 8) != 0 || DEPTH < 2 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_geometry
      $error("sample_capture_ram: DATA_WIDTH must be a multiple of 8 and 2 <= DEPTH <= 2**ADDR_WIDTH");
    end
  endgenerate

  assign cpu_in_range   = ({1'b0, address} < DEPTH_W);
  assign cpu_wr_en      = chipselect & write & cpu_in_range;
  assign cpu_rd_en      = chipselect & read & ~write;
  assign base_in_range  = ({1'b0, cap_base} < DEPTH_W);

  assign snk_ready      = (state == ST_CAPTURE) && (cap_count < cap_len_q);
  assign cap_busy       = (state == ST_CAPTURE);
  assign cap_done       = (state == ST_DONE);
  assign cap_wr_en      = snk_ready & snk_valid;
  assign cap_count_nxt  = cap_count + 1'b1;
  assign cap_wr_ptr_nxt = (cap_wr_ptr == LAST_ADDR) ? '0 : cap_wr_ptr + 1'b1;

  // Capture write is issued after the CPU lanes so it overrides them on an address collision.
  always_ff @(posedge clk) begin
    if (cpu_wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) begin
          mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
    if (cap_wr_en) begin
      mem[cap_wr_ptr] <= snk_data;
    end
  end

  // First read stage samples the array before this edge's writes land, giving read-old-data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_s1 <= 1'b0;
      rd_data_s1  <= '0;
    end else begin
      rd_valid_s1 <= cpu_rd_en;
      if (cpu_rd_en) begin
        rd_data_s1 <= cpu_in_range ? mem[address] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign readdata      = rd_data_s1;
      assign readdatavalid = rd_valid_s1;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_data_s2;
      logic                  rd_valid_s2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_valid_s2 <= 1'b0;
          rd_data_s2  <= '0;
        end else begin
          rd_valid_s2 <= rd_valid_s1;
          if (rd_valid_s1) begin
            rd_data_s2 <= rd_data_s1;
          end
        end
      end

      assign readdata      = rd_data_s2;
      assign readdatavalid = rd_valid_s2;
    end else begin : g_bad_latency
      $error("sample_capture_ram: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // The beat that brings the count up to the length moves straight to DONE;
  // a zero length falls out of CAPTURE on the registered count one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cap_count  <= '0;
      cap_wr_ptr <= '0;
      cap_len_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cap_start) begin
            state      <= ST_CAPTURE;
            cap_wr_ptr <= base_in_range ? cap_base : '0;
            cap_count  <= '0;
            cap_len_q  <= cap_len;
          end
        end
        ST_CAPTURE: begin
          if (!snk_ready) begin
            state <= ST_DONE;
          end else if (snk_valid) begin
            cap_count  <= cap_count_nxt;
            cap_wr_ptr <= cap_wr_ptr_nxt;
            if (cap_count_nxt == cap_len_q) begin
              state <= ST_DONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture_ram.sv
// Directed bench for sample_capture_ram: a two-cycle-latency instance under full test,
// with a one-cycle-latency twin on the same stimulus for read timing.
module tb_sample_capture_ram;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 40;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          cap_start;
  logic [AW-1:0] cap_base;
  logic [AW:0]   cap_len;
  logic          snk_valid;
  logic [DW-1:0] snk_data;

  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          snk_ready;
  logic          cap_busy;
  logic          cap_done;
  logic [AW:0]   cap_count;
  logic [AW-1:0] cap_wr_ptr;

  logic [DW-1:0] readdata_l1;
  logic          readdatavalid_l1;
  logic          snk_ready_l1;
  logic          cap_busy_l1;
  logic          cap_done_l1;
  logic [AW:0]   cap_count_l1;
  logic [AW-1:0] cap_wr_ptr_l1;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [15];

  always #5 clk = ~clk;

  sample_capture_ram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .cap_start(cap_start), .cap_base(cap_base), .cap_len(cap_len),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_count(cap_count), .cap_wr_ptr(cap_wr_ptr)
  );

  sample_capture_ram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")
  ) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata_l1), .readdatavalid(readdatavalid_l1),
    .cap_start(cap_start), .cap_base(cap_base), .cap_len(cap_len),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready_l1),
    .cap_busy(cap_busy_l1), .cap_done(cap_done_l1), .cap_count(cap_count_l1),
    .cap_wr_ptr(cap_wr_ptr_l1)
  );

  function automatic vec_t mk(input logic wr, input logic rd, input logic [AW-1:0] addr,
                              input logic [3:0] be, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] exp);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.be = be; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    chipselect = v.wr | v.rd;
    write      = v.wr;
    read       = v.rd;
    address    = v.addr;
    byteenable = v.be;
    writedata  = v.wdata;
  endtask

  task automatic idleCpu();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  // One CPU transaction followed by two idle cycles, checking valid timing on both latencies.
  task automatic cpuOp(input vec_t v, input string name);
    logic exp_v;
    exp_v = v.rd & ~v.wr;
    applyStimulus(v);
    tick();
    idleCpu();
    checkOutput({name, " lat1 valid"}, 64'(readdatavalid_l1), 64'(exp_v));
    if (exp_v) checkOutput({name, " lat1 data"}, 64'(readdata_l1), 64'(v.exp));
    checkOutput({name, " lat2 early valid"}, 64'(readdatavalid), 64'd0);
    tick();
    checkOutput({name, " lat2 valid"}, 64'(readdatavalid), 64'(exp_v));
    if (exp_v) checkOutput({name, " lat2 data"}, 64'(readdata), 64'(v.exp));
    checkOutput({name, " lat1 late valid"}, 64'(readdatavalid_l1), 64'd0);
  endtask

  task automatic readWord(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    cpuOp(mk(1'b0, 1'b1, addr, 4'h0, '0, exp), name);
  endtask

  task automatic startCapture(input logic [AW-1:0] base, input logic [AW:0] len);
    cap_start = 1'b1;
    cap_base  = base;
    cap_len   = len;
    tick();
    cap_start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b1;
    idleCpu();
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    cap_start  = 1'b0;
    cap_base   = '0;
    cap_len    = '0;
    snk_valid  = 1'b0;
    snk_data   = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset readdatavalid", 64'(readdatavalid), 64'd0);
    checkOutput("reset readdata", 64'(readdata), 64'd0);
    checkOutput("reset busy", 64'(cap_busy), 64'd0);
    checkOutput("reset done", 64'(cap_done), 64'd0);
    checkOutput("reset snk_ready", 64'(snk_ready), 64'd0);
    checkOutput("reset count", 64'(cap_count), 64'd0);
    checkOutput("reset wr_ptr", 64'(cap_wr_ptr), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Preload pattern A000_00nn
    for (int i = 0; i < DEPTH; i++) begin
      cpuOp(mk(1'b1, 1'b0, AW'(i), 4'hF, 32'hA000_0000 | 32'(i), '0), $sformatf("preload%0d", i));
    end

    // Back-to-back reads 0..7
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = AW'(c);
      end else begin
        idleCpu();
      end
      tick();
      checkOutput($sformatf("b2b lat1 valid c%0d", c), 64'(readdatavalid_l1), 64'(c < 8));
      if (c < 8)
        checkOutput($sformatf("b2b lat1 data c%0d", c), 64'(readdata_l1), 64'(32'hA000_0000 | 32'(c)));
      checkOutput($sformatf("b2b lat2 valid c%0d", c), 64'(readdatavalid), 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8)
        checkOutput($sformatf("b2b lat2 data c%0d", c), 64'(readdata), 64'(32'hA000_0000 | 32'(c - 1)));
    end
    idleCpu();

    // Table-driven CPU vectors
    vecs[0]  = mk(1'b1, 1'b0, 6'd5,  4'hF, 32'hAABB_CCDD, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 6'd5,  4'h5, 32'h1122_3344, 32'h0);
    vecs[2]  = mk(1'b0, 1'b1, 6'd5,  4'h0, 32'h0,         32'hAA22_CC44);
    vecs[3]  = mk(1'b1, 1'b0, 6'd45, 4'hF, 32'hDEAD_BEEF, 32'h0);
    vecs[4]  = mk(1'b0, 1'b1, 6'd45, 4'h0, 32'h0,         32'h0);
    vecs[5]  = mk(1'b0, 1'b1, 6'd5,  4'h0, 32'h0,         32'hAA22_CC44);
    vecs[6]  = mk(1'b1, 1'b0, 6'd39, 4'hF, 32'h1234_5678, 32'h0);
    vecs[7]  = mk(1'b0, 1'b1, 6'd39, 4'h0, 32'h0,         32'h1234_5678);
    vecs[8]  = mk(1'b1, 1'b0, 6'd7,  4'h8, 32'h5A00_0000, 32'h0);
    vecs[9]  = mk(1'b0, 1'b1, 6'd7,  4'h0, 32'h0,         32'h5A00_0007);
    vecs[10] = mk(1'b1, 1'b0, 6'd8,  4'h0, 32'hFFFF_FFFF, 32'h0);
    vecs[11] = mk(1'b0, 1'b1, 6'd8,  4'h0, 32'h0,         32'hA000_0008);
    vecs[12] = mk(1'b1, 1'b1, 6'd9,  4'hF, 32'hCAFE_0009, 32'h0);
    vecs[13] = mk(1'b0, 1'b1, 6'd9,  4'h0, 32'h0,         32'hCAFE_0009);
    vecs[14] = mk(1'b0, 1'b1, 6'd63, 4'h0, 32'h0,         32'h0);
    for (int i = 0; i < 15; i++) begin
      cpuOp(vecs[i], $sformatf("vec%0d", i));
    end

    // Wrapping capture: base DEPTH-2, length 4
    startCapture(AW'(DEPTH - 2), 7'd4);
    checkOutput("cap1 busy", 64'(cap_busy), 64'd1);
    checkOutput("cap1 ready", 64'(snk_ready), 64'd1);
    checkOutput("cap1 ptr start", 64'(cap_wr_ptr), 64'(DEPTH - 2));
    checkOutput("cap1 count start", 64'(cap_count), 64'd0);
    for (int b = 1; b <= 4; b++) begin
      snk_valid = 1'b1;
      snk_data  = 32'(b);
      tick();
      checkOutput($sformatf("cap1 count b%0d", b), 64'(cap_count), 64'(b));
      checkOutput($sformatf("cap1 ptr b%0d", b), 64'(cap_wr_ptr), 64'((DEPTH - 2 + b) % DEPTH));
      checkOutput($sformatf("cap1 busy b%0d", b), 64'(cap_busy), 64'(b < 4));
      checkOutput($sformatf("cap1 done b%0d", b), 64'(cap_done), 64'(b == 4));
    end
    snk_valid = 1'b0;
    checkOutput("cap1 ready end", 64'(snk_ready), 64'd0);
    checkOutput("cap1 lat1 done", 64'(cap_done_l1), 64'd1);
    readWord(AW'(DEPTH - 2), 32'd1, "cap1 mem38");
    readWord(AW'(DEPTH - 1), 32'd2, "cap1 mem39");
    readWord(6'd0, 32'd3, "cap1 mem0");
    readWord(6'd1, 32'd4, "cap1 mem1");

    // Zero-length capture with the sink offering data
    snk_valid = 1'b1;
    snk_data  = 32'h77;
    startCapture(6'd20, 7'd0);
    checkOutput("len0 busy", 64'(cap_busy), 64'd1);
    checkOutput("len0 ready", 64'(snk_ready), 64'd0);
    checkOutput("len0 done early", 64'(cap_done), 64'd0);
    tick();
    checkOutput("len0 busy after", 64'(cap_busy), 64'd0);
    checkOutput("len0 done", 64'(cap_done), 64'd1);
    checkOutput("len0 count", 64'(cap_count), 64'd0);
    checkOutput("len0 ptr", 64'(cap_wr_ptr), 64'd20);
    snk_valid = 1'b0;
    readWord(6'd20, 32'hA000_0014, "len0 mem20");

    // cap_start during CAPTURE is ignored
    startCapture(6'd12, 7'd3);
    for (int b = 1; b <= 5; b++) begin
      snk_valid = 1'b1;
      snk_data  = 32'h100 + 32'(b);
      cap_start = (b == 1);
      cap_base  = 6'd30;
      cap_len   = 7'd1;
      tick();
      cap_start = 1'b0;
      if (b == 1) begin
        checkOutput("restart busy", 64'(cap_busy), 64'd1);
        checkOutput("restart count", 64'(cap_count), 64'd1);
        checkOutput("restart ptr", 64'(cap_wr_ptr), 64'd13);
      end
    end
    snk_valid = 1'b0;
    checkOutput("restart final count", 64'(cap_count), 64'd3);
    checkOutput("restart final ptr", 64'(cap_wr_ptr), 64'd15);
    checkOutput("restart done", 64'(cap_done), 64'd1);
    readWord(6'd12, 32'h101, "restart mem12");
    readWord(6'd13, 32'h102, "restart mem13");
    readWord(6'd14, 32'h103, "restart mem14");
    readWord(6'd15, 32'hA000_000F, "restart mem15");
    readWord(6'd30, 32'hA000_001E, "restart mem30");

    // Same-cycle CPU write and capture write to one address
    startCapture(6'd10, 7'd1);
    snk_valid = 1'b1;
    snk_data  = 32'h55;
    applyStimulus(mk(1'b1, 1'b0, 6'd10, 4'hF, 32'h0, 32'h0));
    tick();
    idleCpu();
    snk_valid = 1'b0;
    checkOutput("wcoll done", 64'(cap_done), 64'd1);
    readWord(6'd10, 32'h55, "wcoll mem10");

    // Same-cycle CPU read and capture write: read returns old data
    startCapture(6'd11, 7'd1);
    snk_valid = 1'b1;
    snk_data  = 32'h66;
    applyStimulus(mk(1'b0, 1'b1, 6'd11, 4'h0, 32'h0, 32'h0));
    tick();
    idleCpu();
    snk_valid = 1'b0;
    checkOutput("rcoll lat1 valid", 64'(readdatavalid_l1), 64'd1);
    checkOutput("rcoll lat1 data", 64'(readdata_l1), 64'hA000_000B);
    tick();
    checkOutput("rcoll lat2 valid", 64'(readdatavalid), 64'd1);
    checkOutput("rcoll lat2 data", 64'(readdata), 64'hA000_000B);
    readWord(6'd11, 32'h66, "rcoll mem11");

    // Reset mid-capture with a read in flight
    startCapture(6'd25, 7'd5);
    for (int b = 1; b <= 2; b++) begin
      snk_valid = 1'b1;
      snk_data  = 32'h200 + 32'(b);
      tick();
    end
    snk_valid = 1'b0;
    applyStimulus(mk(1'b0, 1'b1, 6'd3, 4'h0, 32'h0, 32'h0));
    tick();
    idleCpu();
    checkOutput("pre-reset count", 64'(cap_count), 64'd2);
    checkOutput("pre-reset lat1 valid", 64'(readdatavalid_l1), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid reset lat1 valid", 64'(readdatavalid_l1), 64'd0);
    checkOutput("mid reset lat1 data", 64'(readdata_l1), 64'd0);
    checkOutput("mid reset lat2 valid", 64'(readdatavalid), 64'd0);
    checkOutput("mid reset busy", 64'(cap_busy), 64'd0);
    checkOutput("mid reset done", 64'(cap_done), 64'd0);
    checkOutput("mid reset ready", 64'(snk_ready), 64'd0);
    checkOutput("mid reset count", 64'(cap_count), 64'd0);
    checkOutput("mid reset ptr", 64'(cap_wr_ptr), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("post reset lat2 valid c%0d", c), 64'(readdatavalid), 64'd0);
      checkOutput($sformatf("post reset lat1 valid c%0d", c), 64'(readdatavalid_l1), 64'd0);
      checkOutput($sformatf("post reset busy c%0d", c), 64'(cap_busy), 64'd0);
    end
    readWord(6'd25, 32'h201, "reset kept mem25");
    readWord(6'd26, 32'h202, "reset kept mem26");
    readWord(6'd27, 32'hA000_001B, "reset untouched mem27");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
